adxl345_seq_ctrl: RTL and testbench

ADXL345_SEQ_CTRL -- requirements
Module: adxl345_seq_ctrl

---
 rtl/adxl345_seq_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_adxl345_seq_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl345_seq_ctrl.sv
// ADXL345 SPI command sequencer: init register writes, then periodic XYZ burst reads.
// Optional ADXL345_DEVID_CHECK_EN prepends a DEVID read/compare step to the init sequence.
module adxl345_seq_ctrl #(
  parameter int POLL_PERIOD = 1000000,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        enable_poll,
  input  logic        spi_busy,
  input  logic        spi_rvalid,
  input  logic [15:0] spi_rdata,
  input  logic        spi_done,
  output logic        spi_req,
  output logic [7:0]  spi_cmd,
  output logic [7:0]  spi_wdata,
  output logic [1:0]  spi_nwr,
  output logic [1:0]  spi_nrd,
  output logic        spi_ten_bit,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        sample_valid,
  output logic        init_done,
  output logic        error,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    READY = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;
`ifdef ADXL345_DEVID_CHECK_EN
  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] FIRST_STEP = S0;
`else
  localparam logic [1:0] FIRST_STEP = S1;
`endif

  state_t        st;
  logic [1:0]    step;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] wait_cnt;
  logic [1:0]    rx_cnt;
  logic [15:0]   x_tmp, y_tmp, z_tmp;

  logic          rx_take, rx_full, poll_wrap;
  logic [15:0]   rx_word;
  logic [7:0]    t_cmd, t_wdata;
  logic [1:0]    t_nwr, t_nrd;
  logic          t_ten;

  assign state = st;

  always_comb begin
    rx_take   = spi_rvalid && (rx_cnt != 2'd3);
    rx_word   = {spi_rdata[7:0], spi_rdata[15:8]};
    // A burst is complete if three words landed, counting one arriving alongside spi_done
    rx_full   = (rx_cnt == 2'd3) || (rx_take && rx_cnt == 2'd2);
    poll_wrap = (poll_cnt == PW'(POLL_PERIOD - 1));
  end

  always_comb begin
    t_cmd   = 8'h00;
    t_wdata = 8'h00;
    t_nwr   = 2'd0;
    t_nrd   = 2'd0;
    t_ten   = 1'b0;
    case (step)
`ifdef ADXL345_DEVID_CHECK_EN
      S0: begin t_cmd = 8'h80; t_nwr = 2'd1; t_nrd = 2'd1; end
`endif
      S1: begin t_cmd = 8'h31; t_wdata = 8'h04; t_nwr = 2'd2; end
      S2: begin t_cmd = 8'h2D; t_wdata = 8'h08; t_nwr = 2'd2; end
      S3: begin t_cmd = 8'hF2; t_nwr = 2'd1; t_nrd = 2'd3; t_ten = 1'b1; end
      default: ;
    endcase
  end

`ifdef ADXL345_DEVID_CHECK_EN
  logic [7:0] dev_id, id_now;
  always_comb id_now = (rx_take && rx_cnt == 2'd0) ? spi_rdata[15:8] : dev_id;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      step         <= FIRST_STEP;
      poll_cnt     <= '0;
      wait_cnt     <= '0;
      rx_cnt       <= 2'd0;
      x_tmp        <= 16'h0;
      y_tmp        <= 16'h0;
      z_tmp        <= 16'h0;
      spi_req      <= 1'b0;
      spi_cmd      <= 8'h00;
      spi_wdata    <= 8'h00;
      spi_nwr      <= 2'd0;
      spi_nrd      <= 2'd0;
      spi_ten_bit  <= 1'b0;
      x_data       <= 16'h0;
      y_data       <= 16'h0;
      z_data       <= 16'h0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
      error        <= 1'b0;
`ifdef ADXL345_DEVID_CHECK_EN
      dev_id       <= 8'h00;
`endif
    end else begin
      spi_req      <= 1'b0;
      sample_valid <= 1'b0;

      // Poll timer free-runs across S3 transactions so read starts stay POLL_PERIOD apart
      if (init_done && enable_poll)
        poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
      else
        poll_cnt <= '0;

      case (st)
        IDLE: begin
          if (start) begin
            st   <= ISSUE;
            step <= FIRST_STEP;
          end
        end

        ISSUE: begin
          if (!spi_busy) begin
            spi_req     <= 1'b1;
            spi_cmd     <= t_cmd;
            spi_wdata   <= t_wdata;
            spi_nwr     <= t_nwr;
            spi_nrd     <= t_nrd;
            spi_ten_bit <= t_ten;
            wait_cnt    <= '0;
            rx_cnt      <= 2'd0;
            st          <= WAIT;
          end
        end

        WAIT: begin
          if (rx_take) begin
            rx_cnt <= rx_cnt + 2'd1;
            case (rx_cnt)
              2'd0:    x_tmp <= rx_word;
              2'd1:    y_tmp <= rx_word;
              default: z_tmp <= rx_word;
            endcase
`ifdef ADXL345_DEVID_CHECK_EN
            if (rx_cnt == 2'd0) dev_id <= spi_rdata[15:8];
`endif
          end
          if (spi_done) begin
            case (step)
`ifdef ADXL345_DEVID_CHECK_EN
              S0: begin
                if (id_now != 8'hE5) begin
                  st    <= ERROR;
                  error <= 1'b1;
                end else begin
                  step <= S1;
                  st   <= ISSUE;
                end
              end
`endif
              S1: begin
                step <= S2;
                st   <= ISSUE;
              end
              S2: begin
                init_done <= 1'b1;
                step      <= S3;
                st        <= READY;
              end
              default: begin
                if (rx_full) begin
                  x_data       <= x_tmp;
                  y_data       <= y_tmp;
                  z_data       <= (rx_take && rx_cnt == 2'd2) ? rx_word : z_tmp;
                  sample_valid <= 1'b1;
                end
                st <= READY;
              end
            endcase
          end else if (wait_cnt == TW'(TIMEOUT_CYC)) begin
            st        <= ERROR;
            error     <= 1'b1;
            init_done <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        READY: begin
          if (enable_poll && poll_wrap) begin
            step <= S3;
            st   <= ISSUE;
          end
        end

        ERROR: begin
          if (start) begin
            st        <= ISSUE;
            step      <= FIRST_STEP;
            error     <= 1'b0;
            init_done <= 1'b0;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adxl345_seq_ctrl.sv
// Scoreboarded bench for adxl345_seq_ctrl: a simple SPI-master BFM answers each request.
module tb_adxl345_seq_ctrl;
  localparam int PP = 100;
  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        enable_poll = 1'b0;
  logic        spi_busy = 1'b0;
  logic        spi_rvalid = 1'b0;
  logic [15:0] spi_rdata = 16'h0;
  logic        spi_done = 1'b0;
  logic        spi_req;
  logic [7:0]  spi_cmd, spi_wdata;
  logic [1:0]  spi_nwr, spi_nrd;
  logic        spi_ten_bit;
  logic [15:0] x_data, y_data, z_data;
  logic        sample_valid, init_done, error;
  logic [2:0]  state;

  adxl345_seq_ctrl #(.POLL_PERIOD(PP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable_poll(enable_poll),
    .spi_busy(spi_busy), .spi_rvalid(spi_rvalid), .spi_rdata(spi_rdata), .spi_done(spi_done),
    .spi_req(spi_req), .spi_cmd(spi_cmd), .spi_wdata(spi_wdata), .spi_nwr(spi_nwr),
    .spi_nrd(spi_nrd), .spi_ten_bit(spi_ten_bit), .x_data(x_data), .y_data(y_data),
    .z_data(z_data), .sample_valid(sample_valid), .init_done(init_done), .error(error),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [1:0] nwr;
    logic [1:0] nrd;
    logic       ten;
    logic       held;
    int         at;
  } txn_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [15:0] ax_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] dev_word = 16'hE500;
  logic [15:0] ax_w [4];
  int  n_words = 3;
  bit  merge_last = 1'b0;
  bit  withhold = 1'b0;
  bit  bfm_active = 1'b0;
  int  last_req_cyc = 0;
  int  last_done_cyc = 0;
  int  sv_cyc = 0;
  int  sv_count = 0;
  bit  sv_long = 1'b0;
  bit  sv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid) begin
      sv_count = sv_count + 1;
      sv_cyc = cyc;
      if (sv_prev) sv_long = 1'b1;
    end
    sv_prev = sample_valid;
  end

  function automatic logic [75:0] outs();
    return {spi_req, spi_cmd, spi_wdata, spi_nwr, spi_nrd, spi_ten_bit,
            x_data, y_data, z_data, sample_valid, init_done, error, state};
  endfunction

  function automatic bit cur_matches(input txn_t t);
    return (spi_cmd == t.cmd) && (spi_wdata == t.wdata) && (spi_nwr == t.nwr) &&
           (spi_nrd == t.nrd) && (spi_ten_bit == t.ten);
  endfunction

  // SPI master model: busy for the whole transaction, returns words, then done
  initial begin : bfm
    txn_t t;
    int   nw;
    forever begin
      @(negedge clk);
      if (spi_req) begin
        bfm_active = 1'b1;
        spi_busy = 1'b1;
        t.cmd = spi_cmd; t.wdata = spi_wdata; t.nwr = spi_nwr; t.nrd = spi_nrd;
        t.ten = spi_ten_bit; t.held = 1'b1; t.at = cyc;
        last_req_cyc = cyc;
        @(negedge clk);
        @(negedge clk);
        if (t.nrd != 2'd0) begin
          nw = (t.cmd == 8'h80) ? 1 : n_words;
          for (int i = 0; i < nw; i++) begin
            spi_rvalid = 1'b1;
            spi_rdata = (t.cmd == 8'h80) ? dev_word : ax_w[i];
            if (merge_last && !withhold && i == nw - 1) begin
              spi_done = 1'b1;
              last_done_cyc = cyc;
            end
            t.held = t.held & cur_matches(t);
            @(negedge clk);
            spi_rvalid = 1'b0;
          end
        end
        if (withhold) begin
          repeat (TO + 20) @(negedge clk);
        end else if (!spi_done) begin
          spi_done = 1'b1;
          last_done_cyc = cyc;
          t.held = t.held & cur_matches(t);
          @(negedge clk);
        end
        spi_done = 1'b0;
        spi_busy = 1'b0;
        obs_q.push_back(t);
        bfm_active = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && bfm_active; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] c, input logic [7:0] w, input logic [1:0] wr,
                          input logic [1:0] rd, input logic ten);
    txn_t e;
    e.cmd = c; e.wdata = w; e.nwr = wr; e.nrd = rd; e.ten = ten; e.held = 1'b1; e.at = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_init_exp();
`ifdef ADXL345_DEVID_CHECK_EN
    push_exp(8'h80, 8'h00, 2'd1, 2'd1, 1'b0);
`endif
    push_exp(8'h31, 8'h04, 2'd2, 2'd0, 1'b0);
    push_exp(8'h2D, 8'h08, 2'd2, 2'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (outs() !== 76'h0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", outs());
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (outs() !== 76'h0) begin
      n_bad++; $display("FAIL post_reset_hold got %h want 0", outs());
    end
  endtask

  task automatic test_init();
    txn_t e, o;
    obs_q.delete(); exp_q.delete();
    push_init_exp();
    pulse_start();
    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    wait_idle(50);
    n_vec++;
    if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done got %b want 1", init_done); end
    n_vec++;
    if (state !== 3'd3 || error !== 1'b0) begin
      n_bad++; $display("FAIL init_state got state=%0d err=%b want 3/0", state, error);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL init_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if ({o.cmd, o.wdata, o.nwr, o.nrd, o.ten} !== {e.cmd, e.wdata, e.nwr, e.nrd, e.ten}) begin
        n_bad++;
        $display("FAIL init_cmd got %h/%h/%0d/%0d/%b want %h/%h/%0d/%0d/%b",
                 o.cmd, o.wdata, o.nwr, o.nrd, o.ten, e.cmd, e.wdata, e.nwr, e.nrd, e.ten);
      end
      n_vec++;
      if (o.held !== 1'b1) begin n_bad++; $display("FAIL init_hold cmd %h got unstable want stable", o.cmd); end
    end
  endtask

  task automatic test_poll();
    txn_t e, o0, o1;
    int sv0, nobs;
    obs_q.delete(); exp_q.delete(); ax_q.delete();
    ax_w[0] = 16'h3412; ax_w[1] = 16'h7856; ax_w[2] = 16'hBC9A; ax_w[3] = 16'h0000;
    n_words = 3; merge_last = 1'b1;
    ax_q.push_back(16'h1234); ax_q.push_back(16'h5678); ax_q.push_back(16'h9ABC);
    push_exp(8'hF2, 8'h00, 2'd1, 2'd3, 1'b1);
    sv0 = sv_count; sv_long = 1'b0;
    enable_poll = 1'b1;
    for (int i = 0; i < 3 * PP + 50 && obs_q.size() < 2; i++) @(negedge clk);
    enable_poll = 1'b0;
    wait_idle(50);
    nobs = obs_q.size();
    n_vec++;
    if (nobs < 2) begin
      n_bad++; $display("FAIL poll_count got %0d want >=2", nobs);
    end else begin
      e = exp_q.pop_front(); o0 = obs_q.pop_front(); o1 = obs_q.pop_front();
      n_vec++;
      if ({o0.cmd, o0.wdata, o0.nwr, o0.nrd, o0.ten} !== {e.cmd, e.wdata, e.nwr, e.nrd, e.ten}) begin
        n_bad++; $display("FAIL poll_cmd got %h/%0d/%0d/%b want f2/1/3/1", o0.cmd, o0.nwr, o0.nrd, o0.ten);
      end
      n_vec++;
      if (o1.at - o0.at != PP) begin
        n_bad++; $display("FAIL poll_interval got %0d want %0d", o1.at - o0.at, PP);
      end
    end
    n_vec++;
    if (x_data !== ax_q[0] || y_data !== ax_q[1] || z_data !== ax_q[2]) begin
      n_bad++; $display("FAIL poll_xyz got %h %h %h want %h %h %h", x_data, y_data, z_data, ax_q[0], ax_q[1], ax_q[2]);
    end
    n_vec++;
    if (sv_count - sv0 != nobs) begin
      n_bad++; $display("FAIL poll_sv_count got %0d want %0d", sv_count - sv0, nobs);
    end
    n_vec++;
    if (sv_cyc - last_done_cyc != 1 || sv_long !== 1'b0) begin
      n_bad++; $display("FAIL poll_sv_timing got delay=%0d long=%b want 1/0", sv_cyc - last_done_cyc, sv_long);
    end
    merge_last = 1'b0;
  endtask

  task automatic test_poll_stop();
    int sv0;
    ax_q.delete();
    ax_w[0] = 16'h2211; ax_w[1] = 16'h4433; ax_w[2] = 16'h6655; ax_w[3] = 16'hFFEE;
    n_words = 4;
    ax_q.push_back(16'h1122); ax_q.push_back(16'h3344); ax_q.push_back(16'h5566);
    sv0 = sv_count;
    enable_poll = 1'b1;
    for (int i = 0; i < 2 * PP + 20 && !spi_busy; i++) @(negedge clk);
    @(negedge clk);
    enable_poll = 1'b0;
    wait_idle(50);
    n_vec++;
    if (state !== 3'd3) begin n_bad++; $display("FAIL stop_state got %0d want 3", state); end
    n_vec++;
    if (x_data !== ax_q[0] || y_data !== ax_q[1] || z_data !== ax_q[2]) begin
      n_bad++; $display("FAIL stop_xyz got %h %h %h want %h %h %h", x_data, y_data, z_data, ax_q[0], ax_q[1], ax_q[2]);
    end
    n_vec++;
    if (sv_count - sv0 != 1) begin n_bad++; $display("FAIL stop_sv got %0d want 1", sv_count - sv0); end
    obs_q.delete();
    repeat (PP + 20) @(negedge clk);
    n_vec++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL stop_no_poll got %0d req want 0", obs_q.size()); end
  endtask

  task automatic test_partial();
    int sv0;
    ax_w[0] = 16'hAAAA; ax_w[1] = 16'hBBBB; ax_w[2] = 16'hCCCC;
    n_words = 2;
    sv0 = sv_count;
    enable_poll = 1'b1;
    for (int i = 0; i < 2 * PP + 20 && !spi_busy; i++) @(negedge clk);
    enable_poll = 1'b0;
    wait_idle(50);
    n_vec++;
    if (sv_count != sv0) begin n_bad++; $display("FAIL partial_sv got %0d want 0", sv_count - sv0); end
    n_vec++;
    if (x_data !== 16'h1122 || y_data !== 16'h3344 || z_data !== 16'h5566) begin
      n_bad++; $display("FAIL partial_xyz got %h %h %h want 1122 3344 5566", x_data, y_data, z_data);
    end
    n_vec++;
    if (error !== 1'b0 || state !== 3'd3) begin
      n_bad++; $display("FAIL partial_err got err=%b state=%0d want 0/3", error, state);
    end
    n_words = 3;
  endtask

  task automatic test_timeout();
    int elapsed;
    withhold = 1'b1;
    enable_poll = 1'b1;
    for (int i = 0; i < 2 * PP + 20 && !spi_busy; i++) @(negedge clk);
    enable_poll = 1'b0;
    for (int i = 0; i < TO + 60 && !error; i++) @(negedge clk);
    elapsed = cyc - last_req_cyc;
    n_vec++;
    if (error !== 1'b1 || state !== 3'd4) begin
      n_bad++; $display("FAIL timeout_err got err=%b state=%0d want 1/4", error, state);
    end
    n_vec++;
    if (elapsed < TO || elapsed > TO + 2) begin
      n_bad++; $display("FAIL timeout_time got %0d want %0d..%0d", elapsed, TO, TO + 2);
    end
    n_vec++;
    if (init_done !== 1'b0 || spi_req !== 1'b0) begin
      n_bad++; $display("FAIL timeout_flags got init=%b req=%b want 0/0", init_done, spi_req);
    end
    wait_idle(TO + 60);
    withhold = 1'b0;
    obs_q.delete(); exp_q.delete();
    push_init_exp();
    pulse_start();
    @(negedge clk);
    n_vec++;
    if (error !== 1'b0) begin n_bad++; $display("FAIL restart_err got %b want 0", error); end
    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    wait_idle(50);
    n_vec++;
    if (init_done !== 1'b1 || obs_q.size() == 0 || obs_q[0].cmd !== exp_q[0].cmd) begin
      n_bad++; $display("FAIL restart_init got init=%b n=%0d want 1 with cmd %h", init_done, obs_q.size(), exp_q[0].cmd);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] first_cmd;
`ifdef ADXL345_DEVID_CHECK_EN
    first_cmd = 8'h80;
`else
    first_cmd = 8'h31;
`endif
    enable_poll = 1'b1;
    for (int i = 0; i < 2 * PP + 20 && !spi_busy; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs() !== 76'h0) begin n_bad++; $display("FAIL midreset_outputs got %h want 0", outs()); end
    enable_poll = 1'b0;
    wait_idle(50);
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 100 && obs_q.size() == 0; i++) @(negedge clk);
    n_vec++;
    if (obs_q.size() == 0 || obs_q[0].cmd !== first_cmd) begin
      n_bad++; $display("FAIL midreset_first_cmd got n=%0d want cmd %h", obs_q.size(), first_cmd);
    end
    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    wait_idle(50);
  endtask

`ifdef ADXL345_DEVID_CHECK_EN
  task automatic test_devid_fail();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dev_word = 16'h1200;
    pulse_start();
    for (int i = 0; i < 100 && !error; i++) @(negedge clk);
    n_vec++;
    if (error !== 1'b1 || state !== 3'd4) begin
      n_bad++; $display("FAIL devid_err got err=%b state=%0d want 1/4", error, state);
    end
    wait_idle(50);
    obs_q.delete();
    repeat (50) @(negedge clk);
    n_vec++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL devid_no_req got %0d want 0", obs_q.size()); end
    dev_word = 16'hE500;
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_poll();
    test_poll_stop();
    test_partial();
    test_timeout();
    test_reset_mid();
`ifdef ADXL345_DEVID_CHECK_EN
    test_devid_fail();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
